// File: rtl/spiflash_rom_bridge_if.sv
// BRAM-side port bundle of spiflash_rom_bridge: the bridge is the master that
// issues reads; the ROM model/BRAM wrapper connects to the slave modport.
interface spiflash_rom_bridge_if;
    logic [31:0] Addr_A;
    logic        EN_A;
    logic [3:0]  WEN_A;
    logic [31:0] Din_A;
    logic [31:0] Dout_A;
    logic        Clk_A;
    logic        Rst_A;

    modport master (
        output Addr_A, EN_A, WEN_A, Din_A, Clk_A, Rst_A,
        input  Dout_A
    );

    modport slave (
        input  Addr_A, EN_A, WEN_A, Din_A, Clk_A, Rst_A,
        output Dout_A
    );
endinterface

// File: rtl/spiflash_rom_bridge.sv
// Read-only SPI flash slave (mode 0) serving bytes out of a 32-bit BRAM.
// Optional macro SPIFLASH_FASTREAD_EN adds command 0x0B with 8 dummy clocks.
module spiflash_rom_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_BITS   = 24
) (
    input  logic ap_clk,
    input  logic ap_rst,
    input  logic csb,
    input  logic spiclk,
    input  logic io0,
    output logic io1,
    spiflash_rom_bridge_if.master romcode
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;

    state_t                 state_q, state_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [22:0]            shift_q, shift_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [7:0]             out_sh_q, out_sh_d;
    logic [7:0]             next_byte_q, next_byte_d;
    logic [1:0]             lane_q, lane_d;
    logic                   en_q, en_d;
    logic                   cap_q, cap_d;
    logic                   first_q, first_d;
    logic                   io1_q, io1_d;
    logic [31:0]            rom_addr_q, rom_addr_d;

    logic                   csb_s, sclk_s, mosi_s;
    logic                   sclk_rise, sclk_fall;
    logic [7:0]             cmd_byte;
    logic [ADDR_BITS-1:0]   full_addr;
    logic [ADDR_BITS-1:0]   addr_inc;
    logic [7:0]             lane_byte;
    logic                   cmd_fast;
    logic                   go_dummy;
    logic                   fetch;
    logic [ADDR_BITS-1:0]   fetch_addr;

`ifdef SPIFLASH_FASTREAD_EN
    logic fast_q, fast_d;
    assign cmd_fast = (cmd_byte == 8'h0B);
    assign go_dummy = fast_q;
`else
    assign cmd_fast = 1'b0;
    assign go_dummy = 1'b0;
`endif

    always_comb begin
        csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], csb};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spiclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], io0};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    end

    assign csb_s     = csb_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cmd_byte  = {shift_q[6:0], mosi_s};
    assign full_addr = ADDR_BITS'({shift_q, mosi_s});
    assign addr_inc  = addr_q + ADDR_BITS'(1);
    assign lane_byte = romcode.Dout_A[{lane_q, 3'b000} +: 8];

    // Each byte is fetched on the rising edge that completes the previous
    // byte, so the capture lands well inside the following high phase.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        out_sh_d    = out_sh_q;
        next_byte_d = next_byte_q;
        lane_d      = lane_q;
        en_d        = 1'b0;
        cap_d       = en_q;
        first_d     = first_q;
        io1_d       = io1_q;
        rom_addr_d  = rom_addr_q;
        fetch       = 1'b0;
        fetch_addr  = addr_q;
`ifdef SPIFLASH_FASTREAD_EN
        fast_d      = fast_q;
`endif

        if (cap_q) begin
            next_byte_d = lane_byte;
            if (first_q && state_q == ST_DATA) begin
                io1_d    = lane_byte[7];
                out_sh_d = {lane_byte[6:0], 1'b0};
                first_d  = 1'b0;
            end
        end

        if (csb_s) begin
            state_d   = ST_IDLE;
            io1_d     = 1'b0;
            bit_cnt_d = 5'd0;
            first_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    io1_d     = 1'b0;
                    bit_cnt_d = 5'd0;
                    state_d   = ST_CMD;
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_d   = {shift_q[21:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            state_d   = (cmd_byte == 8'h03 || cmd_fast) ? ST_ADDR : ST_IGNORE;
`ifdef SPIFLASH_FASTREAD_EN
                            fast_d    = cmd_fast;
`endif
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        shift_d   = {shift_q[21:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            addr_d    = full_addr;
                            if (go_dummy) begin
                                state_d = ST_DUMMY;
                            end else begin
                                state_d    = ST_DATA;
                                fetch      = 1'b1;
                                fetch_addr = full_addr;
                                first_d    = 1'b1;
                            end
                        end
                    end
                end
                ST_DUMMY: begin
                    io1_d = 1'b0;
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d  = 5'd0;
                            state_d    = ST_DATA;
                            fetch      = 1'b1;
                            fetch_addr = addr_q;
                            first_d    = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d  = 5'd0;
                            addr_d     = addr_inc;
                            fetch      = 1'b1;
                            fetch_addr = addr_inc;
                        end
                    end else if (sclk_fall) begin
                        // A fall at bit 0 starts the prefetched byte; for the
                        // first byte it merely re-drives the bit already shown.
                        if (bit_cnt_q == 5'd0) begin
                            io1_d    = next_byte_q[7];
                            out_sh_d = {next_byte_q[6:0], 1'b0};
                        end else begin
                            io1_d    = out_sh_q[7];
                            out_sh_d = {out_sh_q[6:0], 1'b0};
                        end
                    end
                end
                ST_IGNORE: begin
                    io1_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (fetch) begin
            en_d       = 1'b1;
            rom_addr_d = 32'({fetch_addr[ADDR_BITS-1:2], 2'b00});
            lane_d     = fetch_addr[1:0];
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            csb_sync_q  <= {SYNC_STAGES{1'b1}};
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 5'd0;
            shift_q     <= '0;
            addr_q      <= '0;
            out_sh_q    <= 8'h00;
            next_byte_q <= 8'h00;
            lane_q      <= 2'd0;
            en_q        <= 1'b0;
            cap_q       <= 1'b0;
            first_q     <= 1'b0;
            io1_q       <= 1'b0;
            rom_addr_q  <= 32'h0;
`ifdef SPIFLASH_FASTREAD_EN
            fast_q      <= 1'b0;
`endif
        end else begin
            csb_sync_q  <= csb_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            out_sh_q    <= out_sh_d;
            next_byte_q <= next_byte_d;
            lane_q      <= lane_d;
            en_q        <= en_d;
            cap_q       <= cap_d;
            first_q     <= first_d;
            io1_q       <= io1_d;
            rom_addr_q  <= rom_addr_d;
`ifdef SPIFLASH_FASTREAD_EN
            fast_q      <= fast_d;
`endif
        end
    end

    assign io1            = io1_q;
    assign romcode.Addr_A = rom_addr_q;
    assign romcode.EN_A   = en_q;
    assign romcode.WEN_A  = 4'b0000;
    assign romcode.Din_A  = 32'h0;
    assign romcode.Clk_A  = ap_clk;
    assign romcode.Rst_A  = ap_rst;

endmodule

// File: tb/tb_spiflash_rom_bridge.sv
// Directed bench for spiflash_rom_bridge: drives SPI mode-0 frames against a
// small BRAM model and checks returned bytes and BRAM read addresses.
module tb_spiflash_rom_bridge;

    localparam int HALF = 80;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    logic csb    = 1'b1;
    logic spiclk = 1'b0;
    logic io0    = 1'b0;
    logic io1;

    int checks   = 0;
    int errors   = 0;
    int wen_seen = 0;
    logic [31:0] en_addrs[$];
    logic [7:0]  rx;

    spiflash_rom_bridge_if romcode ();

    spiflash_rom_bridge #(
        .SYNC_STAGES(2),
        .ADDR_BITS  (24)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .csb    (csb),
        .spiclk (spiclk),
        .io0    (io0),
        .io1    (io1),
        .romcode(romcode.master)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [31:0] bram_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0403_0201;
            32'h0000_0004: return 32'h0807_0605;
            32'h0000_0008: return 32'h0C0B_0A09;
            32'h00FF_FFFC: return 32'hDDCC_BBAA;
            default:       return 32'hEEEE_EEEE;
        endcase
    endfunction

    // Synchronous BRAM: data valid one clock after the enable pulse.
    always @(posedge ap_clk) begin
        if (romcode.EN_A === 1'b1)
            romcode.Dout_A <= bram_word(romcode.Addr_A);
    end

    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (romcode.EN_A === 1'b1)
                en_addrs.push_back(romcode.Addr_A);
            if (romcode.WEN_A !== 4'b0000 || romcode.Din_A !== 32'h0)
                wen_seen++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] tx, input int nbits, output logic [7:0] rx_byte);
        rx_byte = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            io0 = tx[7-i];
            #HALF;
            rx_byte[7-i] = io1;
            spiclk = 1'b1;
            #HALF;
            spiclk = 1'b0;
        end
    endtask

    task automatic start_frame();
        @(negedge ap_clk);
        en_addrs.delete();
        csb = 1'b0;
        #HALF;
    endtask

    task automatic end_frame();
        #HALF;
        csb = 1'b1;
        #(4 * HALF);
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [23:0] addr);
        logic [7:0] dummy_rx;
        applyStimulus(cmd, 8, dummy_rx);
        applyStimulus(addr[23:16], 8, dummy_rx);
        applyStimulus(addr[15:8], 8, dummy_rx);
        applyStimulus(addr[7:0], 8, dummy_rx);
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge ap_clk);
        checkOutput("rst_io1", 32'(io1), 32'h0);
        checkOutput("rst_en", 32'(romcode.EN_A), 32'h0);
        checkOutput("rst_addr", romcode.Addr_A, 32'h0);
        ap_rst = 1'b0;
        repeat (5) @(negedge ap_clk);
        checkOutput("idle_io1", 32'(io1), 32'h0);
        checkOutput("idle_en", 32'(romcode.EN_A), 32'h0);
        checkOutput("idle_addr", romcode.Addr_A, 32'h0);
        checkOutput("idle_wen", 32'(romcode.WEN_A), 32'h0);
        checkOutput("idle_din", romcode.Din_A, 32'h0);

        // Read from address 0, eight bytes across two words.
        start_frame();
        send_header(8'h03, 24'h000000);
        for (int b = 0; b < 8; b++) begin
            applyStimulus(8'h00, 8, rx);
            checkOutput($sformatf("rd0_byte%0d", b), 32'(rx), 32'(b + 1));
        end
        end_frame();
        checkOutput("rd0_en_count", 32'(en_addrs.size() >= 8 && en_addrs.size() <= 9), 32'h1);
        checkOutput("rd0_en_first", en_addrs[0], 32'h0);
        checkOutput("rd0_en_word1", en_addrs[4], 32'h4);

        // Unaligned start crossing into the next word.
        start_frame();
        send_header(8'h03, 24'h000002);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(8'h00, 8, rx);
            checkOutput($sformatf("rd2_byte%0d", b), 32'(rx), 32'(b + 3));
        end
        end_frame();
        checkOutput("rd2_en_first", en_addrs[0], 32'h0);
        checkOutput("rd2_en_third", en_addrs[2], 32'h4);

        // Unsupported commands are ignored.
        start_frame();
        applyStimulus(8'hFF, 8, rx);
        applyStimulus(8'h00, 8, rx);
        applyStimulus(8'h00, 8, rx);
        end_frame();
        checkOutput("ign_ff_io1", 32'(rx), 32'h0);
        checkOutput("ign_ff_en", 32'(en_addrs.size()), 32'h0);
        start_frame();
        applyStimulus(8'hAB, 8, rx);
        applyStimulus(8'h00, 8, rx);
        applyStimulus(8'h00, 8, rx);
        end_frame();
        checkOutput("ign_ab_io1", 32'(rx), 32'h0);
        checkOutput("ign_ab_en", 32'(en_addrs.size()), 32'h0);
        start_frame();
        send_header(8'h03, 24'h000004);
        applyStimulus(8'h00, 8, rx);
        end_frame();
        checkOutput("rd4_byte0", 32'(rx), 32'h05);

        // Abort mid-byte, then a clean read must be unaffected.
        start_frame();
        send_header(8'h03, 24'h000000);
        applyStimulus(8'h00, 8, rx);
        checkOutput("abort_byte0", 32'(rx), 32'h01);
        applyStimulus(8'h00, 3, rx);
        end_frame();
        checkOutput("abort_io1_idle", 32'(io1), 32'h0);
        start_frame();
        send_header(8'h03, 24'h000001);
        applyStimulus(8'h00, 8, rx);
        checkOutput("rd1_byte0", 32'(rx), 32'h02);
        applyStimulus(8'h00, 8, rx);
        checkOutput("rd1_byte1", 32'(rx), 32'h03);
        end_frame();

        // Top of the address space wraps to 0.
        start_frame();
        send_header(8'h03, 24'hFFFFFF);
        applyStimulus(8'h00, 8, rx);
        checkOutput("wrap_byte0", 32'(rx), 32'hDD);
        applyStimulus(8'h00, 8, rx);
        checkOutput("wrap_byte1", 32'(rx), 32'h01);
        end_frame();
        checkOutput("wrap_en_first", en_addrs[0], 32'h00FF_FFFC);
        checkOutput("wrap_en_second", en_addrs[1], 32'h0);

        // Fast read command.
        start_frame();
        send_header(8'h0B, 24'h000000);
`ifdef SPIFLASH_FASTREAD_EN
        applyStimulus(8'h00, 8, rx);
        checkOutput("fast_dummy_io1", 32'(rx), 32'h0);
        applyStimulus(8'h00, 8, rx);
        checkOutput("fast_byte0", 32'(rx), 32'h01);
        applyStimulus(8'h00, 8, rx);
        checkOutput("fast_byte1", 32'(rx), 32'h02);
        end_frame();
        checkOutput("fast_en_first", en_addrs[0], 32'h0);
`else
        applyStimulus(8'h00, 8, rx);
        checkOutput("fast_off_io1_a", 32'(rx), 32'h0);
        applyStimulus(8'h00, 8, rx);
        checkOutput("fast_off_io1_b", 32'(rx), 32'h0);
        end_frame();
        checkOutput("fast_off_en", 32'(en_addrs.size()), 32'h0);
`endif

        checkOutput("no_writes", 32'(wen_seen), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spiflash_rom_bridge.md
Name: spiflash_rom_bridge

Overview:
- Read-only SPI flash slave (mode 0, single-bit) for the Caravel SoC flash port; serves instruction fetches from a synchronous BRAM holding the firmware image.
- Sits between the management core's flash_csb/flash_clk/flash_io0/flash_io1 pins and a 32-bit BRAM port (romcode_*).
- SPI inputs are oversampled in the ap_clk domain, so no second clock is used.

Parameters:
- SYNC_STAGES, 2, flops in each synchronizer for csb, spiclk and io0 (minimum 2).
- ADDR_BITS, 24, width of the SPI byte address; higher address bits wrap.

Ports:
- ap_clk  in  1  single system clock; all logic is posedge ap_clk.
- ap_rst  in  1  asynchronous, active-high reset.
- csb  in  1  SPI chip select, active low.
- spiclk  in  1  SPI clock from the master.
- io0  in  1  MOSI; command/address bits, MSB first.
- io1  out  1  MISO; read data, MSB first.
- romcode_Addr_A  out  32  BRAM byte address; always word aligned.
- romcode_EN_A  out  1  BRAM read enable, one-cycle pulse.
- romcode_WEN_A  out  4  byte write enables; constant 4'b0000.
- romcode_Din_A  out  32  write data; constant 0.
- romcode_Dout_A  in  32  BRAM read data; valid 1 ap_clk after the EN pulse.
- romcode_Clk_A  out  1  equals ap_clk.
- romcode_Rst_A  out  1  equals ap_rst.

Behaviour:
- Reset (async, ap_rst=1): state IDLE, io1=0, romcode_EN_A=0, romcode_Addr_A=0, all shift/bit counters 0.
- Input conditioning: csb, spiclk and io0 each pass through SYNC_STAGES flops. A spiclk rise or fall event is detected by comparing the last two synced samples.
- Input timing constraint: each spiclk high and low phase lasts at least 4 ap_clk cycles.
- csb: synced csb=1 forces state IDLE and io1=0 from any state, mid-byte included. Partial bits are discarded.
- Shifting: io0 is sampled on synced spiclk rising events. io1 is updated on synced spiclk falling events, except that the first data bit is driven as soon as it becomes available.
- State IDLE: go to CMD when synced csb falls; bit counter cleared.
- State CMD: shift in 8 bits. Command 0x03 goes to ADDR. Any other command (0xFF, 0xAB, etc.) goes to IGNORE.
- State IGNORE: io1=0, no BRAM access, stay until csb rises.
- State ADDR: shift in 24 address bits, MSB first, then go to DATA.
- State DATA, per byte: compute word address {8'h00, addr[23:2], 2'b00}, pulse romcode_EN_A for one cycle, capture romcode_Dout_A on the following cycle, and select the byte lane.
- Byte lanes are little-endian: addr[1:0]=0 selects Dout[7:0] and addr[1:0]=3 selects Dout[31:24].
- Fetch timing: the fetch for a byte completes before the first spiclk fall that shifts out that byte's bit 7. It is issued on the rising event of the previous byte's last bit, or of the last address bit for the first byte.
- Shift-out order: bit 7 first; after 8 bits the address increments by 1.
- Address wrap: the address wraps from 2^ADDR_BITS-1 to 0.
- Streaming: data continues indefinitely while csb stays low.
- BRAM port: at most one read per byte, never any write.

Optional Feature:
- Macro SPIFLASH_FASTREAD_EN.
- When defined, command 0x0B (FAST READ) is accepted: 24 address bits, then 8 dummy clocks (io1=0, no BRAM access), then DATA exactly as for 0x03.
- When undefined, 0x0B is treated like any other unknown command and goes to IGNORE.

Test Plan:
- Reset with ap_rst=1, then release: io1=0, romcode_EN_A=0, romcode_Addr_A=0, romcode_WEN_A=0, romcode_Din_A=0.
- BRAM word0=0x04030201, word1=0x08070605. Send 0x03 + address 0x000000 and clock 64 data bits: io1 bytes 01 02 03 04 05 06 07 08. EN pulses are seen at Addr 0x0 then 0x4.
- Same BRAM contents, address 0x000002: bytes 03 04 05 06, crossing the word boundary.
- Send 0xFF then 0xAB in separate csb frames: io1 stays 0 and there is no EN pulse. Then send 0x03 at address 0x000004: first byte 0x05.
- Raise csb mid-byte during DATA, then start a new 0x03 read at 0x000001: first byte 0x02 with no corruption. Separately, a read at 0xFFFFFF returns byte 3 of that word, then word0 byte 0x01.
- With SPIFLASH_FASTREAD_EN: send 0x0B, address 0x000000, 8 dummy clocks: bytes 01 02. Without the macro: io1=0 and no EN.
